// File: rtl/tanh_poly_pipe_pkg.sv
// Shared constants and helpers for the pipelined tanh evaluator:
// Q.20 coefficient table, quantisation, clamp and saturation.
package tanh_pkg;

  localparam int MAX_TERMS = 8;
  localparam int COEF_FRAC = 20;

  // Q.20 coefficients. A0..A4 are fitted values and A5..A7 are Taylor terms.
  localparam int A0_Q20 = -349696;
  localparam int A1_Q20 = 139776;
  localparam int A2_Q20 = -56832;
  localparam int A3_Q20 = 22528;
  localparam int A4_Q20 = -9216;
  localparam int A5_Q20 = 3767;
  localparam int A6_Q20 = -1527;
  localparam int A7_Q20 = 619;

  function automatic int coef_q20(input int k);
    case (k)
      0:       return A0_Q20;
      1:       return A1_Q20;
      2:       return A2_Q20;
      3:       return A3_Q20;
      4:       return A4_Q20;
      5:       return A5_Q20;
      6:       return A6_Q20;
      7:       return A7_Q20;
      default: return 0;
    endcase
  endfunction

  // Round-to-nearest (half up) from Q.20 to the requested fraction width.
  function automatic int coef(input int k, input int frac);
    int c;
    c = coef_q20(k);
    if (frac >= COEF_FRAC) return c <<< (frac - COEF_FRAC);
    return (c + (1 <<< (COEF_FRAC - frac - 1))) >>> (COEF_FRAC - frac);
  endfunction

  function automatic longint clamp_val(input longint x, input longint lim);
    if (x > lim)  return lim;
    if (x < -lim) return -lim;
    return x;
  endfunction

  function automatic logic out_of_range(input longint x, input longint lim);
    return (x > lim) || (x < -lim);
  endfunction

  function automatic longint sat_val(input longint x, input int w);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/tanh_poly_pipe_horner_step.sv
// One Horner step h' = (h*x2 >>> FRAC) + A(k), split into a multiply stage
// and an add stage, with x_c/x2/range carried alongside.
module horner_step
  import tanh_pkg::*;
#(
  parameter int W    = 14,
  parameter int FRAC = 12,
  parameter int COEF = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         valid_d,
  input  logic [W-1:0] h_d,
  input  logic [W-1:0] x2_d,
  input  logic [W-1:0] xc_d,
  input  logic         range_d,
  output logic         valid_q,
  output logic [W-1:0] h_q,
  output logic [W-1:0] x2_q,
  output logic [W-1:0] xc_q,
  output logic         range_q
);

  localparam logic signed [W-1:0] COEF_W = W'(COEF);

  logic signed [2*W-1:0] h_ext;
  logic signed [2*W-1:0] x2_ext;
  logic signed [2*W-1:0] m_p;
  logic                  m_valid;
  logic        [W-1:0]   m_x2;
  logic        [W-1:0]   m_xc;
  logic                  m_range;

  assign h_ext  = {{W{h_d[W-1]}}, h_d};
  assign x2_ext = {{W{x2_d[W-1]}}, x2_d};

  // Both stages freeze together when the output is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_p     <= '0;
      m_x2    <= '0;
      m_xc    <= '0;
      m_range <= 1'b0;
      valid_q <= 1'b0;
      h_q     <= '0;
      x2_q    <= '0;
      xc_q    <= '0;
      range_q <= 1'b0;
    end else if (en) begin
      m_valid <= valid_d;
      m_p     <= h_ext * x2_ext;
      m_x2    <= x2_d;
      m_xc    <= xc_d;
      m_range <= range_d;
      valid_q <= m_valid;
      h_q     <= W'(m_p >>> FRAC) + COEF_W;
      x2_q    <= m_x2;
      xc_q    <= m_xc;
      range_q <= m_range;
    end
  end

endmodule

// File: rtl/tanh_poly_pipe.sv
// Fully pipelined fixed-point tanh(x) = x + x^3*P(x^2) with valid/ready
// back-pressure, input clamping and saturating final add.
module tanh_poly_pipe
  import tanh_pkg::*;
#(
  parameter int W       = 14,
  parameter int FRAC    = 12,
  parameter int N_TERMS = 5,
  parameter int XMAX    = 1 << FRAC
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_x,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [W-1:0] o_fx,
  output logic         o_range,
  output logic         o_valid,
  input  logic         i_ready
);

  logic en;

  // The whole pipe moves as one; it only halts when a result is waiting.
  assign en      = i_ready || !o_valid;
  assign o_ready = en;

  logic signed [W-1:0]   x_in;
  logic                  s0_valid;
  logic signed [W-1:0]   s0_xc;
  logic                  s0_range;
  logic signed [2*W-1:0] s0_ext;

  logic                  s1_valid;
  logic signed [W-1:0]   s1_xc;
  logic signed [W-1:0]   s1_x2;
  logic                  s1_range;

  assign x_in   = i_x;
  assign s0_ext = {{W{s0_xc[W-1]}}, s0_xc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s0_xc    <= '0;
      s0_range <= 1'b0;
      s1_valid <= 1'b0;
      s1_xc    <= '0;
      s1_x2    <= '0;
      s1_range <= 1'b0;
    end else if (en) begin
      s0_valid <= i_valid;
      s0_xc    <= W'(clamp_val(longint'(x_in), longint'(XMAX)));
      s0_range <= out_of_range(longint'(x_in), longint'(XMAX));
      s1_valid <= s0_valid;
      s1_xc    <= s0_xc;
      s1_x2    <= W'((s0_ext * s0_ext) >>> FRAC);
      s1_range <= s0_range;
    end
  end

  // Element 0 is the S1 output; element j+1 is the output of Horner step j.
  logic                hv [N_TERMS];
  logic signed [W-1:0] hh [N_TERMS];
  logic signed [W-1:0] hx2 [N_TERMS];
  logic signed [W-1:0] hxc [N_TERMS];
  logic                hr [N_TERMS];

  assign hv[0]  = s1_valid;
  assign hh[0]  = W'(coef(N_TERMS - 1, FRAC));
  assign hx2[0] = s1_x2;
  assign hxc[0] = s1_xc;
  assign hr[0]  = s1_range;

  for (genvar j = 0; j < N_TERMS - 1; j++) begin : g_step
    horner_step #(
      .W    (W),
      .FRAC (FRAC),
      .COEF (coef(N_TERMS - 2 - j, FRAC))
    ) u_step (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .valid_d (hv[j]),
      .h_d     (hh[j]),
      .x2_d    (hx2[j]),
      .xc_d    (hxc[j]),
      .range_d (hr[j]),
      .valid_q (hv[j+1]),
      .h_q     (hh[j+1]),
      .x2_q    (hx2[j+1]),
      .xc_q    (hxc[j+1]),
      .range_q (hr[j+1])
    );
  end

  logic signed [2*W-1:0] h_ext;
  logic signed [2*W-1:0] x2_ext;
  logic                  t1_valid;
  logic signed [W-1:0]   t1_t;
  logic signed [W-1:0]   t1_xc;
  logic                  t1_range;
  logic signed [2*W-1:0] t_ext;
  logic signed [2*W-1:0] xc_ext;
  logic                  t2_valid;
  logic signed [W-1:0]   t2_u;
  logic signed [W-1:0]   t2_xc;
  logic                  t2_range;

  assign h_ext  = {{W{hh[N_TERMS-1][W-1]}}, hh[N_TERMS-1]};
  assign x2_ext = {{W{hx2[N_TERMS-1][W-1]}}, hx2[N_TERMS-1]};
  assign t_ext  = {{W{t1_t[W-1]}}, t1_t};
  assign xc_ext = {{W{t1_xc[W-1]}}, t1_xc};

  // Tail: x^2*P, then x^3*P, then the saturating add back onto x.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t1_valid <= 1'b0;
      t1_t     <= '0;
      t1_xc    <= '0;
      t1_range <= 1'b0;
      t2_valid <= 1'b0;
      t2_u     <= '0;
      t2_xc    <= '0;
      t2_range <= 1'b0;
      o_valid  <= 1'b0;
      o_fx     <= '0;
      o_range  <= 1'b0;
    end else if (en) begin
      t1_valid <= hv[N_TERMS-1];
      t1_t     <= W'((h_ext * x2_ext) >>> FRAC);
      t1_xc    <= hxc[N_TERMS-1];
      t1_range <= hr[N_TERMS-1];
      t2_valid <= t1_valid;
      t2_u     <= W'((t_ext * xc_ext) >>> FRAC);
      t2_xc    <= t1_xc;
      t2_range <= t1_range;
      o_valid  <= t2_valid;
      o_fx     <= W'(sat_val(longint'(t2_xc) + longint'(t2_u), W));
      o_range  <= t2_range;
    end
  end

endmodule
